// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with a single-entry valid/ready output stream.
// The serial line is synchronised, a start bit is confirmed at mid-bit,
// data bits are sampled at their centres, and the stop bit is checked.
// A completed byte goes into a one-deep holding register. The register
// reports overrun when a byte arrives while the consumer has not taken
// the previous one.
module uart_rx_stream #(
    parameter int F    = 8000000,
    parameter int BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    // Clocks per bit (rounded) and half-bit offset used to find the bit centre
    localparam int N     = (F + BAUD / 2) / BAUD;
    localparam int H     = N / 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic             rx_meta_q;
    logic             rx_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       sh_q,    sh_d;
    logic             done_q,  done_d;
    logic             ferr_q,  ferr_d;

    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;
    logic             hs;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver state register, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing: confirm start at mid-bit, then sample once per bit period
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        // Low pulse shorter than half a bit: treat as line noise
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == N_LAST) begin
                    cnt_d        = '0;
                    sh_d[idx_q]  = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == N_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Low stop bit: drop the byte and wait out the break
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register and stream flags
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // A completed byte is accepted if the slot is empty or is being emptied this cycle
    always_comb begin
        hs      = valid_q & ready;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (done_q) begin
            if (!valid_q || hs) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
